fb_regfile_mp: RTL



---
 rtl/fb_regfile_mp_if.sv | 40 ++++
 rtl/fb_regfile_mp.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fb_regfile_mp_if.sv
`default_nettype none
// =============================================================================
// Module   : fb_regfile_mp_if
// Brief    : Bus bundle for fb_regfile_mp: read ports, two writebacks, issue/flush.
// Revision : 1.0
// =============================================================================
interface fb_regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                w0_en;
  logic [AW-1:0]       w0_addr;
  logic [XLEN-1:0]     w0_data;
  logic                w1_en;
  logic [AW-1:0]       w1_addr;
  logic [XLEN-1:0]     w1_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic                ready;

  modport master (
    output rd_addr, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
           iss_en, iss_addr, flush,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  rd_addr, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
           iss_en, iss_addr, flush,
    output rd_data, rd_busy, ready
  );
endinterface
`default_nettype wire

// File: rtl/fb_regfile_mp.sv
`default_nettype none
// =============================================================================
// Module   : fb_regfile_mp
// Brief    : Multi-port register file with write-pending scoreboard and init
//            sweep. Optional write-to-read bypass: FB_REGFILE_BYPASS_EN.
// Revision : 1.0
// =============================================================================
module fb_regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
) (
  input  wire logic      clk,
  input  wire logic      reset_n,
  fb_regfile_mp_if.slave bus
);
  localparam int            AW         = $clog2(NREG);
  localparam logic [AW-1:0] C_LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] C_ONE      = AW'(1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_nxt;
  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_run;
  logic            w_w0_act;
  logic            w_w1_act;
  logic            w_iss_act;

  assign w_run     = (r_state == ST_RUN);
  assign w_w0_act  = w_run && bus.w0_en  && (bus.w0_addr  != '0);
  assign w_w1_act  = w_run && bus.w1_en  && (bus.w1_addr  != '0);
  assign w_iss_act = w_run && bus.iss_en && (bus.iss_addr != '0);
  assign bus.ready = w_run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_idx   <= C_ONE;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_INIT: begin
        w_idx_nxt = r_idx + C_ONE;
        if (r_idx == C_LAST_IDX) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_idx_nxt = r_idx;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // Storage has no reset; the sweep zeroes it. Later NBA gives W1 priority.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_idx] <= '0;
    end else begin
      if (w_w0_act) begin
        r_mem[bus.w0_addr] <= bus.w0_data;
      end
      if (w_w1_act) begin
        r_mem[bus.w1_addr] <= bus.w1_data;
      end
    end
  end

  // Set after clear so a newer producer stays pending; flush overrides both.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_w0_act) begin
      w_busy_nxt[bus.w0_addr] = 1'b0;
    end
    if (w_w1_act) begin
      w_busy_nxt[bus.w1_addr] = 1'b0;
    end
    if (w_iss_act) begin
      w_busy_nxt[bus.iss_addr] = 1'b1;
    end
    if (w_run && bus.flush) begin
      w_busy_nxt = '0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_data;
      logic            w_busy;

      assign w_addr = bus.rd_addr[k*AW +: AW];

      always_comb begin
        w_data = r_mem[w_addr];
        w_busy = r_busy[w_addr];
`ifdef FB_REGFILE_BYPASS_EN
        if (w_w1_act && (bus.w1_addr == w_addr)) begin
          w_data = bus.w1_data;
          w_busy = 1'b0;
        end else if (w_w0_act && (bus.w0_addr == w_addr)) begin
          w_data = bus.w0_data;
          w_busy = 1'b0;
        end
`else
        w_data = r_mem[w_addr];
`endif
        if (!w_run || (w_addr == '0)) begin
          w_data = '0;
          w_busy = 1'b0;
        end
      end

      assign bus.rd_data[k*XLEN +: XLEN] = w_data;
      assign bus.rd_busy[k]              = w_busy;
    end
  endgenerate
endmodule
`default_nettype wire
